dispatch_packetizer: RTL and testbench

- Builds wormhole dispatch packets for the bypass/NoD dispatch channel. Sits directly upstream of the bypass controller's dispatch input (INDATA/INVALID/INREADY).
- Takes one packet request (destination chip ID, destination router ID, length) plus a raw payload word stream.
- Emits a HEAD flit followed by LEN payload flits; the last payload flit is typed TAIL and the earlier ones are typed BODY.
- Output is registered and sustains one flit per cycle under continuous ready.

---
 rtl/dispatch_packetizer_pkg.sv | 38 +++
 rtl/flit_out_reg.sv | 41 ++++
 rtl/dispatch_packetizer.sv | 108 ++++++++++
 tb/tb_dispatch_packetizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_packetizer_pkg.sv
// ============================================================================
// Module  : dispatch_packetizer_pkg
// Purpose : Flit layout, flit type codes and FSM states shared by the
//           dispatch packetizer and its output register.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package dispatch_packetizer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TYPE_H     = 31;
  localparam int TYPE_L     = 30;
  localparam int DCID_H     = 29;
  localparam int DCID_L     = 26;
  localparam int DRID_H     = 25;
  localparam int DRID_L     = 22;
  localparam int RTID_H     = 21;
  localparam int RTID_L     = 18;
  localparam int SCID_H     = 17;
  localparam int SCID_L     = 14;
  localparam int PKT_LEN_W  = 8;
  localparam int HEAD_LEN_L = 0;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } pkt_state_e;

endpackage

`default_nettype wire

// File: rtl/flit_out_reg.sv
// ============================================================================
// Module  : flit_out_reg
// Purpose : Single-entry valid/ready output register; load_en tells the
//           producer when a new flit may be presented.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module flit_out_reg #(
  parameter int W = 32
) (
  input  logic         CDCLK,
  input  logic         CDRESETn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         load_en,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign load_en   = ~r_valid | out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load_en) begin
      r_valid <= in_valid;
      if (in_valid) r_data <= in_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dispatch_packetizer.sv
// ============================================================================
// Module  : dispatch_packetizer
// Purpose : Builds HEAD + LEN payload flits (last one TAIL) for the bypass
//           dispatch channel from a request and a raw payload stream.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dispatch_packetizer
  import dispatch_packetizer_pkg::*;
#(
  parameter int NODID      = 0,
  parameter int LOCAL_RTID = 0,
  parameter int LEN_W      = PKT_LEN_W
) (
  input  logic                     CDCLK,
  input  logic                     CDRESETn,
  input  logic [DCID_H-DCID_L:0]   REQDCID,
  input  logic [DRID_H-DRID_L:0]   REQDRID,
  input  logic [LEN_W-1:0]         REQLEN,
  input  logic                     REQVALID,
  output logic                     REQREADY,
  input  logic [DATA_WIDTH-3:0]    PLDATA,
  input  logic                     PLVALID,
  output logic                     PLREADY,
  output logic [DATA_WIDTH-1:0]    OUTDATA,
  output logic                     OUTVALID,
  input  logic                     OUTREADY
);

  localparam int SCID_W = SCID_H - SCID_L + 1;
  localparam int RTID_W = RTID_H - RTID_L + 1;
  localparam logic [SCID_W-1:0] c_nodid = SCID_W'(NODID);
  localparam logic [RTID_W-1:0] c_rtid  = RTID_W'(LOCAL_RTID);

  pkt_state_e              r_state;
  logic [LEN_W-1:0]        r_rem;
  logic                    w_load_en;
  logic                    w_req_fire;
  logic                    w_pl_fire;
  logic                    w_last;
  logic [LEN_W-1:0]        w_eff_len;
  logic                    w_in_valid;
  logic [DATA_WIDTH-1:0]   w_head;
  logic [DATA_WIDTH-1:0]   w_body;
  logic [DATA_WIDTH-1:0]   w_in_data;

  assign REQREADY   = (r_state == ST_IDLE)    & w_load_en;
  assign PLREADY    = (r_state == ST_PAYLOAD) & w_load_en;
  assign w_req_fire = REQVALID & REQREADY;
  assign w_pl_fire  = PLVALID & PLREADY;
  // A zero-length request still carries one payload flit
  assign w_eff_len  = (REQLEN == '0) ? LEN_W'(1) : REQLEN;
  assign w_last     = (r_rem == LEN_W'(1));

  always_comb begin
    w_head                         = '0;
    w_head[TYPE_H:TYPE_L]          = FLIT_HEAD;
    w_head[DCID_H:DCID_L]          = REQDCID;
    w_head[DRID_H:DRID_L]          = REQDRID;
    w_head[RTID_H:RTID_L]          = c_rtid;
    w_head[SCID_H:SCID_L]          = c_nodid;
    w_head[HEAD_LEN_L +: LEN_W]    = w_eff_len;
  end

  assign w_body     = {(w_last ? FLIT_TAIL : FLIT_BODY), PLDATA};
  assign w_in_data  = w_req_fire ? w_head : w_body;
  assign w_in_valid = w_req_fire | w_pl_fire;

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_rem   <= w_eff_len;
            r_state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_pl_fire) begin
            r_rem <= r_rem - LEN_W'(1);
            if (w_last) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  flit_out_reg #(
    .W (DATA_WIDTH)
  ) u_out_reg (
    .CDCLK     (CDCLK),
    .CDRESETn  (CDRESETn),
    .in_valid  (w_in_valid),
    .in_data   (w_in_data),
    .load_en   (w_load_en),
    .out_valid (OUTVALID),
    .out_data  (OUTDATA),
    .out_ready (OUTREADY)
  );

endmodule

`default_nettype wire

// File: tb/tb_dispatch_packetizer.sv
// ============================================================================
// Module  : tb_dispatch_packetizer
// Purpose : Scoreboard bench for dispatch_packetizer: vector table plus
//           latency, backpressure, back-to-back and reset sequences.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dispatch_packetizer;

  logic        CDCLK = 1'b0;
  logic        CDRESETn;
  logic [3:0]  REQDCID, REQDRID;
  logic [7:0]  REQLEN;
  logic        REQVALID, REQREADY;
  logic [29:0] PLDATA;
  logic        PLVALID, PLREADY;
  logic [31:0] OUTDATA;
  logic        OUTVALID, OUTREADY;

  always #5 CDCLK = ~CDCLK;

  dispatch_packetizer #(.NODID(0), .LOCAL_RTID(3), .LEN_W(8)) dut (
    .CDCLK(CDCLK), .CDRESETn(CDRESETn),
    .REQDCID(REQDCID), .REQDRID(REQDRID), .REQLEN(REQLEN),
    .REQVALID(REQVALID), .REQREADY(REQREADY),
    .PLDATA(PLDATA), .PLVALID(PLVALID), .PLREADY(PLREADY),
    .OUTDATA(OUTDATA), .OUTVALID(OUTVALID), .OUTREADY(OUTREADY)
  );

  typedef struct {
    logic [3:0] dcid;
    logic [3:0] drid;
    logic [7:0] len;
    int         rdy_mode;
    int         pl_gap;
    int         exp_flits;
    int         exp_left;
  } vec_t;

  typedef struct {
    logic [3:0] dcid;
    logic [3:0] drid;
    logic [7:0] len;
  } req_t;

  req_t        req_q[$];
  logic [29:0] pl_q[$];
  logic [31:0] exp_q[$];
  vec_t        vecs[6];

  int n_vec = 0, n_bad = 0, cyc = 0, mdl_rem = 0;
  int n_out = 0, first_out = -1, last_out = -1, req_cyc = 0;
  int rdy_mode = 0, pl_gap = 0;
  bit hold_low = 1'b0;
  logic [31:0] held;

  function automatic logic [31:0] exp_head(logic [3:0] dcid, logic [3:0] drid, logic [7:0] len);
    logic [31:0] f = 32'h0;
    f[31:30] = 2'b01;
    f[29:26] = dcid;
    f[25:22] = drid;
    f[21:18] = 4'd3;
    f[7:0]   = (len == 8'd0) ? 8'd1 : len;
    return f;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    REQVALID = (req_q.size() > 0);
    REQDCID  = REQVALID ? req_q[0].dcid : 4'd0;
    REQDRID  = REQVALID ? req_q[0].drid : 4'd0;
    REQLEN   = REQVALID ? req_q[0].len  : 8'd0;
    PLVALID  = (pl_q.size() > 0) && (pl_gap == 0 || (cyc % 2) == 0);
    PLDATA   = (pl_q.size() > 0) ? pl_q[0] : 30'd0;
    if (hold_low)           OUTREADY = 1'b0;
    else if (rdy_mode == 0) OUTREADY = 1'b1;
    else if (rdy_mode == 1) OUTREADY = 1'($urandom_range(0, 1));
    else                    OUTREADY = ((cyc % 3) != 0);
  endtask

  // Sample handshakes mid-cycle, then advance one clock and re-drive
  task automatic step();
    logic rf, pf, of;
    @(negedge CDCLK);
    rf = REQVALID & REQREADY;
    pf = PLVALID & PLREADY;
    of = OUTVALID & OUTREADY;
    if (of) begin
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (exp_q.size() == 0) check("unexpected_flit", OUTDATA, 32'hxxxxxxxx);
      else check("flit", OUTDATA, exp_q.pop_front());
    end
    if (rf) begin
      check("req_accept_busy", 32'(mdl_rem), 32'd0);
      mdl_rem = (REQLEN == 8'd0) ? 1 : int'(REQLEN);
      exp_q.push_back(exp_head(REQDCID, REQDRID, REQLEN));
      req_cyc = cyc;
      void'(req_q.pop_front());
    end
    if (pf) begin
      check("pl_accept_idle", 32'(mdl_rem == 0), 32'd0);
      exp_q.push_back({(mdl_rem == 1) ? 2'b11 : 2'b10, PLDATA});
      if (mdl_rem > 0) mdl_rem--;
      void'(pl_q.pop_front());
    end
    @(posedge CDCLK);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run(int budget);
    int k = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0 || mdl_rem != 0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) check("drain_timeout", 32'(k), 32'(budget - 1));
  endtask

  task automatic clear_model();
    req_q.delete(); pl_q.delete(); exp_q.delete();
    mdl_rem = 0;
  endtask

  task automatic new_pkt(logic [3:0] dcid, logic [3:0] drid, logic [7:0] len, int words);
    req_q.push_back('{dcid, drid, len});
    for (int i = 0; i < words; i++) pl_q.push_back(30'($urandom));
  endtask

  initial begin
    vecs[0] = '{4'd2,  4'd5,  8'd3,   0, 0,   4, 0};
    vecs[1] = '{4'd1,  4'd1,  8'd0,   0, 0,   2, 1};
    vecs[2] = '{4'd3,  4'd7,  8'd255, 1, 0, 256, 0};
    vecs[3] = '{4'd4,  4'd9,  8'd5,   0, 1,   6, 0};
    vecs[4] = '{4'd15, 4'd15, 8'd6,   1, 1,   7, 0};
    vecs[5] = '{4'd0,  4'd0,  8'd1,   2, 0,   2, 0};

    CDRESETn = 1'b0;
    drive();
    repeat (3) @(posedge CDCLK);
    #1;
    check("rst_outvalid", 32'(OUTVALID), 32'd0);
    check("rst_outdata",  OUTDATA,       32'd0);
    check("rst_reqready", 32'(REQREADY), 32'd1);
    check("rst_plready",  32'(PLREADY),  32'd0);
    CDRESETn = 1'b1;

    foreach (vecs[v]) begin
      rdy_mode = vecs[v].rdy_mode;
      pl_gap   = vecs[v].pl_gap;
      n_out    = 0;
      new_pkt(vecs[v].dcid, vecs[v].drid, vecs[v].len,
              (vecs[v].len == 0) ? 2 : int'(vecs[v].len));
      drive();
      run(3000);
      check($sformatf("v%0d_nflits", v), 32'(n_out), 32'(vecs[v].exp_flits));
      check($sformatf("v%0d_pl_left", v), 32'(pl_q.size()), 32'(vecs[v].exp_left));
      check($sformatf("v%0d_idle_outvalid", v), 32'(OUTVALID), 32'd0);
      pl_q.delete();
    end

    // Single packet: HEAD one cycle after acceptance, 4 flits back to back
    rdy_mode = 0; pl_gap = 0; n_out = 0; first_out = -1;
    req_q.push_back('{4'd2, 4'd5, 8'd3});
    pl_q.push_back(30'hA); pl_q.push_back(30'hB); pl_q.push_back(30'hC);
    drive();
    run(50);
    check("head_latency", 32'(first_out - req_cyc), 32'd1);
    check("burst_span",   32'(last_out - first_out), 32'd3);
    check("burst_nflits", 32'(n_out), 32'd4);

    // Backpressure for 5 cycles while a BODY flit is held
    n_out = 0;
    new_pkt(4'd6, 4'd2, 8'd3, 3);
    drive();
    for (int k = 0; k < 20 && !(OUTVALID && OUTDATA[31:30] == 2'b10); k++) step();
    check("bp_body_seen", 32'(OUTDATA[31:30]), 32'd2);
    hold_low = 1'b1;
    drive();
    held = OUTDATA;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_stable",   OUTDATA,       held);
      check("bp_valid",    32'(OUTVALID), 32'd1);
      check("bp_plready",  32'(PLREADY),  32'd0);
    end
    hold_low = 1'b0;
    drive();
    run(50);
    check("bp_nflits", 32'(n_out), 32'd4);

    // Back-to-back packets: no bubble between first TAIL and second HEAD
    n_out = 0; first_out = -1;
    new_pkt(4'd1, 4'd2, 8'd2, 2);
    new_pkt(4'd3, 4'd4, 8'd2, 2);
    drive();
    run(50);
    check("b2b_nflits", 32'(n_out), 32'd6);
    check("b2b_span",   32'(last_out - first_out), 32'd5);

    // Reset after HEAD and one BODY abandons the packet
    n_out = 0;
    new_pkt(4'd5, 4'd6, 8'd4, 4);
    drive();
    for (int k = 0; k < 20 && n_out < 2; k++) step();
    CDRESETn = 1'b0;
    #1;
    check("midrst_outvalid", 32'(OUTVALID), 32'd0);
    check("midrst_reqready", 32'(REQREADY), 32'd1);
    clear_model();
    drive();
    @(posedge CDCLK);
    #1;
    CDRESETn = 1'b1;
    n_out = 0;
    new_pkt(4'd7, 4'd8, 8'd2, 2);
    drive();
    run(50);
    check("postrst_nflits", 32'(n_out), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
